// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: ALU control codes,
// compound request opcodes, FSM state encoding and response flag layout.
package alu_issue_pkg;

  // ALU operation select codes
  typedef enum logic [2:0] {
    ALU_LOAD_A = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_AND    = 3'd3,
    ALU_INCREM = 3'd4,
    ALU_NOT_A  = 3'd5,
    ALU_XOR    = 3'd6,
    ALU_LOAD_B = 3'd7
  } alu_ctrl_e;

  // Compound request opcodes (0-7 pass straight through to the ALU)
  localparam logic [3:0] OP_BEQ = 4'd8;
  localparam logic [3:0] OP_BNE = 4'd9;
  localparam logic [3:0] OP_BLT = 4'd10;
  localparam logic [3:0] OP_BGT = 4'd11;
  localparam logic [3:0] OP_BLE = 4'd12;
  localparam logic [3:0] OP_BGE = 4'd13;
  localparam logic [3:0] OP_SLT = 4'd14;
  localparam logic [3:0] OP_ABS = 4'd15;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC1 = 3'd1,
    ST_EXEC2 = 3'd2,
    ST_TRAP  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Bit positions inside rsp_flags
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_EQ   = 3;
  localparam int FLAG_LT   = 4;
  localparam int FLAG_GT   = 5;

  // ALU select used during the first execute pass
  function automatic logic [2:0] exec1_ctrl(input logic [3:0] op);
    logic [2:0] ctrl;
    if (op[3] == 1'b0) begin
      ctrl = op[2:0];
    end else if (op == OP_ABS) begin
      ctrl = ALU_LOAD_A;
    end else begin
      ctrl = ALU_SUB;
    end
    return ctrl;
  endfunction

  // Raw ALU ops whose signed overflow is a trap condition
  function automatic logic op_can_trap(input logic [3:0] op);
    return (op == 4'd1) || (op == 4'd2) || (op == 4'd4);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_cond.sv
// Branch / SLT condition evaluator: maps the opcode and the ALU compare
// flags to a taken bit (0 for non-branch ops) and the SLT result bit.
module alu_issue_cond
  import alu_issue_pkg::*;
(
  input  logic [3:0] op,
  input  logic       equal_to,
  input  logic       less_than,
  input  logic       greater_than,
  output logic       taken,
  output logic       slt_bit
);

  // Select the branch condition for the current opcode
  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = equal_to;
      OP_BNE:  taken = ~equal_to;
      OP_BLT:  taken = less_than;
      OP_BGT:  taken = greater_than;
      OP_BLE:  taken = less_than | equal_to;
      OP_BGE:  taken = greater_than | equal_to;
      default: taken = 1'b0;
    endcase
  end

  // SLT result bit, forced low for every other opcode
  always_comb begin
    if (op == OP_SLT) begin
      slt_bit = less_than;
    end else begin
      slt_bit = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts requests, sequences one or two ALU passes,
// evaluates branch/SLT conditions and returns a registered response.
// Optional overflow trapping is built when ALU_ISSUE_TRAP_EN is defined.
module alu_issue_ctrl
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_out,
  input  logic        zero,
  input  logic        negative,
  input  logic        overflow,
  input  logic        equal_to,
  input  logic        less_than,
  input  logic        greater_than,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [5:0]  rsp_flags,
  output logic        rsp_taken,
  output logic        rsp_trap,
  output logic        trap,
  input  logic        trap_ack
);

  state_e      state_r;
  logic [3:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] alu_a_r;
  logic [31:0] alu_b_r;
  logic [2:0]  alu_ctrl_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_result_r;
  logic [5:0]  rsp_flags_r;
  logic        rsp_taken_r;

  logic [5:0]  flags_s;
  logic [31:0] cap_result_s;
  logic        abs_neg_s;
  logic        taken_s;
  logic        slt_bit_s;

  alu_issue_cond u_cond (
    .op           (op_r),
    .equal_to     (equal_to),
    .less_than    (less_than),
    .greater_than (greater_than),
    .taken        (taken_s),
    .slt_bit      (slt_bit_s)
  );

  // Pack the ALU flags and pick the value captured after the first pass
  always_comb begin
    flags_s = {greater_than, less_than, equal_to, overflow, negative, zero};
    if (op_r == OP_SLT) begin
      cap_result_s = {31'd0, slt_bit_s};
    end else begin
      cap_result_s = alu_out;
    end
    if (op_r == OP_ABS) begin
      abs_neg_s = negative;
    end else begin
      abs_neg_s = 1'b0;
    end
  end

`ifdef ALU_ISSUE_TRAP_EN
  logic trap_r;
  logic rsp_trap_r;
  logic trap_hit_s;

  // Overflow trap qualification for the pass that is ending this cycle
  always_comb begin
    if (state_r == ST_EXEC2) begin
      trap_hit_s = overflow;
    end else if (state_r == ST_EXEC1) begin
      trap_hit_s = overflow & op_can_trap(op_r);
    end else begin
      trap_hit_s = 1'b0;
    end
  end

  assign trap     = trap_r;
  assign rsp_trap = rsp_trap_r;
`else
  logic unused_trap_ack_s;
  assign unused_trap_ack_s = trap_ack;
  assign trap              = 1'b0;
  assign rsp_trap          = 1'b0;
`endif

  // Request/response sequencing with registered ALU drive and payload
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      op_r         <= 4'd0;
      a_r          <= 32'd0;
      alu_a_r      <= 32'd0;
      alu_b_r      <= 32'd0;
      alu_ctrl_r   <= 3'd0;
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= 32'd0;
      rsp_flags_r  <= 6'd0;
      rsp_taken_r  <= 1'b0;
`ifdef ALU_ISSUE_TRAP_EN
      trap_r       <= 1'b0;
      rsp_trap_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            op_r       <= req_op;
            a_r        <= req_a;
            alu_a_r    <= req_a;
            alu_b_r    <= req_b;
            alu_ctrl_r <= exec1_ctrl(req_op);
            state_r    <= ST_EXEC1;
          end
        end
        ST_EXEC1: begin
          rsp_result_r <= cap_result_s;
          rsp_flags_r  <= flags_s;
          rsp_taken_r  <= taken_s;
          if (abs_neg_s) begin
            // Second pass computes 0 - a for a negative ABS operand
            alu_a_r    <= 32'd0;
            alu_b_r    <= a_r;
            alu_ctrl_r <= ALU_SUB;
            state_r    <= ST_EXEC2;
          end else begin
            alu_a_r    <= 32'd0;
            alu_b_r    <= 32'd0;
            alu_ctrl_r <= 3'd0;
`ifdef ALU_ISSUE_TRAP_EN
            if (trap_hit_s) begin
              trap_r  <= 1'b1;
              state_r <= ST_TRAP;
            end else begin
              rsp_valid_r <= 1'b1;
              state_r     <= ST_RESP;
            end
`else
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
`endif
          end
        end
        ST_EXEC2: begin
          rsp_result_r <= alu_out;
          rsp_flags_r  <= flags_s;
          rsp_taken_r  <= 1'b0;
          alu_a_r      <= 32'd0;
          alu_b_r      <= 32'd0;
          alu_ctrl_r   <= 3'd0;
`ifdef ALU_ISSUE_TRAP_EN
          if (trap_hit_s) begin
            trap_r  <= 1'b1;
            state_r <= ST_TRAP;
          end else begin
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end
`else
          rsp_valid_r <= 1'b1;
          state_r     <= ST_RESP;
`endif
        end
`ifdef ALU_ISSUE_TRAP_EN
        ST_TRAP: begin
          if (trap_ack) begin
            trap_r      <= 1'b0;
            rsp_trap_r  <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
`ifdef ALU_ISSUE_TRAP_EN
            rsp_trap_r  <= 1'b0;
`endif
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          alu_a_r     <= 32'd0;
          alu_b_r     <= 32'd0;
          alu_ctrl_r  <= 3'd0;
`ifdef ALU_ISSUE_TRAP_EN
          trap_r      <= 1'b0;
          rsp_trap_r  <= 1'b0;
`endif
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_r == ST_IDLE) & ~reset;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_ctrl   = alu_ctrl_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = rsp_result_r;
  assign rsp_flags  = rsp_flags_r;
  assign rsp_taken  = rsp_taken_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with an ALU model attached to the
// DUT's ALU port and a wide-arithmetic reference model for expectations.
module tb_alu_issue_ctrl;

`ifdef ALU_ISSUE_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_ctrl;
  logic        zero, negative, overflow, equal_to, less_than, greater_than;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [5:0]  rsp_flags;
  logic        rsp_taken, rsp_trap, trap, trap_ack;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  typedef struct {
    logic [31:0] result;
    logic [5:0]  flags;
    logic        taken;
    logic        trap;
    int          lat;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  bit mon_en    = 1'b0;
  bit stall_req = 1'b0;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
    .zero(zero), .negative(negative), .overflow(overflow),
    .equal_to(equal_to), .less_than(less_than), .greater_than(greater_than),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_taken(rsp_taken), .rsp_trap(rsp_trap),
    .trap(trap), .trap_ack(trap_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Combinational 32-bit ALU seen by the DUT (bit-level overflow rules)
  function automatic logic [37:0] alu_bits(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] c);
    logic [31:0] r;
    logic v;
    v = 1'b0;
    case (c)
      3'd0: r = a;
      3'd1: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd2: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd3: r = a & b;
      3'd4: begin r = a + 32'd1; v = (a == 32'h7FFF_FFFF); end
      3'd5: r = ~a;
      3'd6: r = a ^ b;
      default: r = b;
    endcase
    return {($signed(a) > $signed(b)), ($signed(a) < $signed(b)), (a == b),
            v, r[31], (r == 32'd0), r};
  endfunction

  assign {greater_than, less_than, equal_to, overflow, negative, zero, alu_out} =
         alu_bits(alu_a, alu_b, alu_ctrl);

  // Reference ALU computed with 64-bit signed arithmetic
  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input int c,
                                  output logic [31:0] r, output logic [5:0] fl);
    longint sa, sb, w;
    logic v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    v  = 1'b0;
    case (c)
      1: begin w = sa + sb; r = 32'(w); v = (w > 64'sd2147483647) || (w < -64'sd2147483648); end
      2: begin w = sa - sb; r = 32'(w); v = (w > 64'sd2147483647) || (w < -64'sd2147483648); end
      4: begin w = sa + 64'sd1; r = 32'(w); v = (w > 64'sd2147483647); end
      0: r = a;
      3: r = a & b;
      5: r = ~a;
      6: r = a ^ b;
      default: r = b;
    endcase
    fl = {(sa > sb), (sa < sb), (sa == sb), v, r[31], (r == 32'd0)};
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic eq, lt, gt;
    e.taken = 1'b0; e.trap = 1'b0; e.lat = 2; e.acc = 0;
    if (op < 4'd8) begin
      ref_alu(a, b, int'(op), e.result, e.flags);
      e.trap = TRAP_EN && (op == 4'd1 || op == 4'd2 || op == 4'd4) && e.flags[2];
    end else if (op == 4'd15) begin
      if (a[31]) begin
        ref_alu(32'd0, a, 2, e.result, e.flags);
        e.lat  = 3;
        e.trap = TRAP_EN && e.flags[2];
      end else begin
        ref_alu(a, b, 0, e.result, e.flags);
      end
    end else begin
      ref_alu(a, b, 2, e.result, e.flags);
      eq = e.flags[3]; lt = e.flags[4]; gt = e.flags[5];
      case (op)
        4'd8:  e.taken = eq;
        4'd9:  e.taken = !eq;
        4'd10: e.taken = lt;
        4'd11: e.taken = gt;
        4'd12: e.taken = lt || eq;
        4'd13: e.taken = gt || eq;
        default: begin e.taken = 1'b0; e.result = {31'd0, lt}; end
      endcase
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cycle);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(6, 0))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      5: return 32'($urandom_range(20, 0));
      default: return $urandom;
    endcase
  endfunction

  // Issue one request (called at a negedge); pushes the expectation on accept
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    exp_t e;
    n = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_accept_timeout", 64'(req_ready), 64'd1);
    end else begin
      e = model(op, a, b);
      e.acc = cycle;
      exp_q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 4'($urandom); req_a = $urandom; req_b = $urandom;
    repeat ($urandom_range(2, 0)) @(negedge clk);
  endtask

  // Monitor: timing, stability and payload checks, plus rsp_ready/trap_ack drive
  initial begin
    bit rsp_seen, trap_seen, ack_given, held;
    int trap_rise, ack_cycle, stall_left;
    logic [31:0] h_res;
    logic [5:0]  h_fl;
    logic        h_tk, h_tr;
    exp_t e;
    rsp_seen = 0; trap_seen = 0; ack_given = 0; held = 0;
    trap_rise = 0; ack_cycle = 0; stall_left = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rsp_valid) chk("req_ready_low_in_resp", 64'(req_ready), 64'd0);
        if (held) begin
          chk("hold_valid", 64'(rsp_valid), 64'd1);
          chk("hold_result", 64'(rsp_result), 64'(h_res));
          chk("hold_flags", 64'(rsp_flags), 64'(h_fl));
          chk("hold_taken", 64'(rsp_taken), 64'(h_tk));
          chk("hold_trap", 64'(rsp_trap), 64'(h_tr));
        end
        if (trap && !trap_seen) begin
          trap_seen = 1; trap_rise = cycle;
          if (exp_q.size() == 0) chk("trap_unexpected", 64'd1, 64'd0);
          else begin
            chk("trap_expected", 64'd1, 64'(exp_q[0].trap));
            chk("trap_latency", 64'(trap_rise - exp_q[0].acc), 64'(exp_q[0].lat));
          end
        end
        if (rsp_valid && !rsp_seen) begin
          rsp_seen = 1;
          if (stall_req) begin stall_left = 4; stall_req = 0; end
          if (exp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
          else if (exp_q[0].trap) chk("rsp_after_ack", 64'(cycle), 64'(ack_cycle + 1));
          else chk("rsp_latency", 64'(cycle - exp_q[0].acc), 64'(exp_q[0].lat));
        end
        if (trap) begin
          if (!ack_given && (cycle - trap_rise) >= 2) begin
            trap_ack = 1'b1; ack_given = 1; ack_cycle = cycle;
          end else begin
            trap_ack = 1'b0;
          end
        end else begin
          trap_ack = ($urandom_range(7, 0) == 0);
        end
        if (rsp_valid) begin
          if (stall_left > 0) begin rsp_ready = 1'b0; stall_left--; end
          else rsp_ready = ($urandom_range(3, 0) != 0);
        end else begin
          rsp_ready = 1'($urandom_range(1, 0));
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_result", 64'(rsp_result), 64'(e.result));
            chk("rsp_flags", 64'(rsp_flags), 64'(e.flags));
            chk("rsp_taken", 64'(rsp_taken), 64'(e.taken));
            chk("rsp_trap", 64'(rsp_trap), 64'(e.trap));
          end
          held = 0; rsp_seen = 0; trap_seen = 0; ack_given = 0;
        end else if (rsp_valid) begin
          held = 1; h_res = rsp_result; h_fl = rsp_flags; h_tk = rsp_taken; h_tr = rsp_trap;
        end else begin
          held = 0;
        end
      end
    end
  end

  // Main stimulus sequence
  initial begin
    int n;
    reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0;
    rsp_ready = 1'b0; trap_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_result", 64'(rsp_result), 64'd0);
    chk("reset_rsp_flags", 64'(rsp_flags), 64'd0);
    chk("reset_rsp_taken", 64'(rsp_taken), 64'd0);
    chk("reset_rsp_trap", 64'(rsp_trap), 64'd0);
    chk("reset_trap", 64'(trap), 64'd0);
    chk("reset_alu_a", 64'(alu_a), 64'd0);
    chk("reset_alu_b", 64'(alu_b), 64'd0);
    chk("reset_alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'd1);
    mon_en = 1'b1;

    send(4'd1,  32'd5,          32'd7);
    send(4'd1,  32'h7FFF_FFFF,  32'd1);
    send(4'd10, 32'hFFFF_FFFF,  32'd1);
    send(4'd13, 32'hFFFF_FFFF,  32'd1);
    send(4'd15, 32'hFFFF_FFF6,  32'd0);
    send(4'd15, 32'h8000_0000,  32'd0);
    send(4'd14, 32'hFFFF_FFFF,  32'd1);
    stall_req = 1'b1;
    send(4'd6,  32'h1234_5678,  32'h0F0F_0F0F);
    send(4'd4,  32'h7FFF_FFFF,  32'd0);
    for (int i = 0; i < 300; i++) send(4'($urandom_range(15, 0)), pick(), pick());

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    mon_en = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0; trap_ack = 1'b0;
    @(negedge clk);

    // Reset during EXEC1 discards the in-flight op
    req_valid = 1'b1; req_op = 4'd1; req_a = 32'd3; req_b = 32'd4;
    chk("pre_reset_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("exec1_alu_ctrl", 64'(alu_ctrl), 64'd1);
    chk("exec1_alu_a", 64'(alu_a), 64'd3);
    chk("exec1_alu_b", 64'(alu_b), 64'd4);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_reset_alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("mid_reset_req_ready", 64'(req_ready), 64'd0);
    chk("mid_reset_trap", 64'(trap), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_req_ready", 64'(req_ready), 64'd1);
    repeat (3) @(negedge clk);
    chk("post_reset_no_rsp", 64'(rsp_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Request-side controller for the 32-bit ALU. Accepts operation requests over a valid/ready handshake and drives the ALU's operand and `alu_ctrl` inputs. Captures the ALU result and flags, evaluates compare/branch conditions, and returns a registered response over a second valid/ready handshake. It sits between decode and the ALU, and owns multi-pass ops and overflow trapping.

## Interface
- No parameters; the data width is fixed at 32.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when high with `req_valid`.
- `req_op`  in  4  opcode:
  - 0–7: raw ALU op, with `alu_ctrl = req_op[2:0]`.
  - 8–13: BEQ, BNE, BLT, BGT, BLE, BGE.
  - 14: SLT.
  - 15: ABS.
- `req_a`, `req_b`  in  32  operands.
- `alu_a`, `alu_b`  out  32  ALU operand drive.
- `alu_ctrl`  out  3  ALU op select.
- `alu_out`  in  32  ALU result.
- `zero`, `negative`, `overflow`, `equal_to`, `less_than`, `greater_than`  in  1 each  ALU flags.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_result`  out  32  result.
- `rsp_flags`  out  6  captured flags, packed as `{greater_than, less_than, equal_to, overflow, negative, zero}`.
- `rsp_taken`  out  1  branch condition true; 0 for non-branch ops.
- `rsp_trap`  out  1  response came from a trapped overflow.
- `trap`  out  1  overflow trap pending.
- `trap_ack`  in  1  releases a pending trap.

## Operation
- States: IDLE, EXEC1, EXEC2, TRAP, RESP.
- IDLE:
  - `req_ready` = 1; it is 0 in every other state and 0 while `reset` is high.
  - On handshake, register the op and operands, then go to EXEC1.
- EXEC1: drive the ALU from the registered values.
  - Ops 0–7: `alu_ctrl` = op.
  - Ops 8–14: SUB.
  - Op 15: LOAD_A.
  - Capture `alu_out` and flags at the end of the cycle.
- Result and branch rules:
  - Branch ops: result = `a - b`; taken is BEQ eq, BNE !eq, BLT lt, BGT gt, BLE lt|eq, BGE gt|eq.
  - SLT: result = `{31'b0, less_than}`.
- ABS: if `negative` is seen in EXEC1, go to EXEC2; otherwise the result is `a` and the FSM goes to RESP.
- EXEC2: drive `alu_a = 0`, `alu_b = a`, `alu_ctrl` = SUB; capture result and flags.
- Trap eligibility: overflow on ADD (1), SUB (2), INCREM (4), or ABS EXEC2 goes to TRAP; otherwise the FSM goes to RESP. Compare ops never trap.
- TRAP:
  - `trap` = 1 and the captured payload is held.
  - On `trap_ack`, go to RESP with `rsp_trap` = 1.
- RESP:
  - `rsp_valid` = 1; payload is stable until `rsp_ready`.
  - On handshake, go to IDLE.
- Outside EXEC1/EXEC2, ALU drive holds `alu_a = 0`, `alu_b = 0`, `alu_ctrl` = 000.

## Timing
- Request accepted in cycle T; EXEC1 runs at T+1.
- `rsp_valid` rises at T+2. ABS with a negative operand responds at T+3.
- A trapped op has `trap` rising at the same cycle the response would have appeared. The response follows one cycle after `trap_ack`.
- The earliest next request is accepted the cycle after the response handshake, giving a 3-cycle minimum initiation interval.
- Reset values: state IDLE; `rsp_valid`, `rsp_taken`, `rsp_trap` and `trap` all 0; `rsp_result` and `rsp_flags` 0; `alu_a`, `alu_b` and `alu_ctrl` 0.
- Reset in any state returns to IDLE next cycle. It drops `rsp_valid` and `trap` and discards the in-flight op.
- `trap_ack` outside TRAP is ignored. `rsp_ready` outside RESP is ignored.

## Configuration
- Macro: `ALU_ISSUE_TRAP_EN`.
- Defined: overflow trapping as described in Operation.
- Undefined:
  - The TRAP state is not built; overflow is reported only via `rsp_flags[2]`.
  - `trap` and `rsp_trap` are tied 0, and `trap_ack` is ignored.

## Structure
- Package `alu_issue_pkg` holds:
  - ALU ctrl codes: LOAD_A, ADD, SUB, AND, INCREM, NOT_A, XOR, LOAD_B.
  - `req_op` codes 8–15.
  - The FSM state enum.
  - Flag bit indices within `rsp_flags`.
- One sub-module, `alu_issue_cond`: combinational branch/SLT evaluator taking the opcode and the three compare flags.

## Test plan
- ADD a=5, b=7 -> `rsp_valid` at T+2, `rsp_result` = 12, `zero` = 0, `rsp_taken` = 0.
- With `ALU_ISSUE_TRAP_EN`: ADD a=0x7FFFFFFF, b=1 -> `trap` at T+2, held 3 cycles until `trap_ack`; then `rsp_valid` with `rsp_trap` = 1, result 0x80000000, overflow flag 1. Without the macro: response at T+2 with `rsp_trap` = 0 and overflow flag 1.
- BLT a=0xFFFFFFFF, b=1 -> `rsp_taken` = 1, result 0xFFFFFFFE. BGE on the same operands -> `rsp_taken` = 0.
- ABS a=0xFFFFFFF6 -> response at T+3, result 10. ABS a=0x80000000 -> overflow, trap path.
- Hold `rsp_ready` low 4 cycles -> `rsp_valid` and payload stable, `req_ready` = 0 throughout.
- Assert `reset` during EXEC1 -> next cycle IDLE, `rsp_valid` = 0, `alu_ctrl` = 0, `req_ready` = 1 after reset is released.
